// File: rtl/memory_cycle.sv
// Memory stage of a 5-stage RISC-V pipeline: 1024x32 data memory with
// combinational read, plus the M/W pipeline register and writeback mux.
module memory_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALU_ResultM,
  output logic        RegWriteW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic        ResultSrcW,
  output logic [31:0] ResultW
);

  typedef struct packed {
    logic        reg_write;
    logic        result_src;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
    logic [31:0] alu_result;
    logic [31:0] read_data;
  } mw_t;

  // Contents start at zero and deliberately survive reset.
  logic [31:0] mem_q [1024] = '{default: 32'h0};

  logic [9:0]  word_idx;
  logic [31:0] rd_word;
  mw_t         mw_d, mw_q;

  assign word_idx = ALU_ResultM[11:2];
  assign rd_word  = mem_q[word_idx];

  always_ff @(posedge clk) begin
    if (rst && MemWriteM) mem_q[word_idx] <= WriteDataM;
  end

  always_comb begin
    mw_d            = '0;
    mw_d.reg_write  = RegWriteM;
    mw_d.result_src = ResultSrcM;
    mw_d.rd         = RD_M;
    mw_d.pc_plus4   = PCPlus4M;
    mw_d.alu_result = ALU_ResultM;
    mw_d.read_data  = rd_word;
  end

  always_ff @(posedge clk) begin
    if (!rst) mw_q <= '0;
    else      mw_q <= mw_d;
  end

  assign RegWriteW   = mw_q.reg_write;
  assign ResultSrcW  = mw_q.result_src;
  assign RD_W        = mw_q.rd;
  assign PCPlus4W    = mw_q.pc_plus4;
  assign ALU_ResultW = mw_q.alu_result;
  assign ReadDataW   = mw_q.read_data;
  assign ResultW     = mw_q.result_src ? mw_q.read_data : mw_q.alu_result;

endmodule
